// File: rtl/csa_pipe_adder.sv
// csa_pipe_adder: pipelined conditional-sum adder/subtractor with valid/ready
// flow control. Each merge level doubles the block size. Every block carries
// two {carry, sum} candidates, one for block carry-in 0 and one for carry-in 1.
// The real carry-in only picks between the two final candidates at the end.
module csa_pipe_adder #(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int L = $clog2(WIDTH);

    logic             en;
    logic             v0_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] bp_q;
    logic [WIDTH-1:0] bp_d;
    logic             c_q;
    logic             c_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             cout_q;
    logic             cout_d;
    logic             ovf_q;
    logic             ovf_d;

    // Global stall: every stage moves together whenever the output can drain.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    // Subtraction is A + ~B + 1, so the operand is inverted and the carry-in forced.
    always_comb begin
        bp_d = sub ? ~b : b;
        c_d  = sub | cin;
    end

    // Stage 0: input register. Only the valid bit is reset; the data may go stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q <= 1'b0;
        end else if (en) begin
            v0_q <= in_valid;
            a_q  <= a;
            bp_q <= bp_d;
            c_q  <= c_d;
        end
    end

    // Level k holds WIDTH>>k blocks of 2^k bits each. s0/c0 are the candidates
    // for block carry-in 0, and s1/c1 are the candidates for block carry-in 1.
    genvar k;
    generate
        for (k = 0; k <= L; k++) begin : g_lvl
            localparam int unsigned NB = WIDTH >> k;

            logic [WIDTH-1:0] s0;
            logic [WIDTH-1:0] s1;
            logic [NB-1:0]    c0;
            logic [NB-1:0]    c1;
            logic             v;
            logic             c;
            logic             am;
            logic             bm;

            if (k == 0) begin : g_base
                assign s0 = a_q ^ bp_q;
                assign s1 = ~(a_q ^ bp_q);
                assign c0 = a_q & bp_q;
                assign c1 = a_q | bp_q;
                assign v  = v0_q;
                assign c  = c_q;
                assign am = a_q[WIDTH-1];
                assign bm = bp_q[WIDTH-1];
            end else begin : g_merge
                localparam int unsigned H = 1 << (k - 1);

                logic [WIDTH-1:0] m_s0;
                logic [WIDTH-1:0] m_s1;
                logic [NB-1:0]    m_c0;
                logic [NB-1:0]    m_c1;

                // Merge block pairs: the lower block's candidate carries select the upper block's candidates.
                always_comb begin
                    m_s0 = '0;
                    m_s1 = '0;
                    m_c0 = '0;
                    m_c1 = '0;
                    for (int unsigned j = 0; j < NB; j++) begin
                        m_s0[2*j*H +: H]   = g_lvl[k-1].s0[2*j*H +: H];
                        m_s1[2*j*H +: H]   = g_lvl[k-1].s1[2*j*H +: H];
                        m_s0[2*j*H+H +: H] = g_lvl[k-1].c0[2*j] ? g_lvl[k-1].s1[2*j*H+H +: H]
                                                                : g_lvl[k-1].s0[2*j*H+H +: H];
                        m_c0[j]            = g_lvl[k-1].c0[2*j] ? g_lvl[k-1].c1[2*j+1]
                                                                : g_lvl[k-1].c0[2*j+1];
                        m_s1[2*j*H+H +: H] = g_lvl[k-1].c1[2*j] ? g_lvl[k-1].s1[2*j*H+H +: H]
                                                                : g_lvl[k-1].s0[2*j*H+H +: H];
                        m_c1[j]            = g_lvl[k-1].c1[2*j] ? g_lvl[k-1].c1[2*j+1]
                                                                : g_lvl[k-1].c0[2*j+1];
                    end
                end

                if ((k % REG_EVERY == 0) && (k < L)) begin : g_cut
                    logic [WIDTH-1:0] s0_q;
                    logic [WIDTH-1:0] s1_q;
                    logic [NB-1:0]    c0_q;
                    logic [NB-1:0]    c1_q;
                    logic             v_q;
                    logic             c_q;
                    logic             am_q;
                    logic             bm_q;

                    // Pipeline cut after this merge level. Side-band bits travel with the data.
                    always_ff @(posedge clk) begin
                        if (rst) begin
                            v_q <= 1'b0;
                        end else if (en) begin
                            v_q  <= g_lvl[k-1].v;
                            s0_q <= m_s0;
                            s1_q <= m_s1;
                            c0_q <= m_c0;
                            c1_q <= m_c1;
                            c_q  <= g_lvl[k-1].c;
                            am_q <= g_lvl[k-1].am;
                            bm_q <= g_lvl[k-1].bm;
                        end
                    end

                    assign s0 = s0_q;
                    assign s1 = s1_q;
                    assign c0 = c0_q;
                    assign c1 = c1_q;
                    assign v  = v_q;
                    assign c  = c_q;
                    assign am = am_q;
                    assign bm = bm_q;
                end else begin : g_pass
                    assign s0 = m_s0;
                    assign s1 = m_s1;
                    assign c0 = m_c0;
                    assign c1 = m_c1;
                    assign v  = g_lvl[k-1].v;
                    assign c  = g_lvl[k-1].c;
                    assign am = g_lvl[k-1].am;
                    assign bm = g_lvl[k-1].bm;
                end
            end
        end
    endgenerate

    // The real carry-in picks the whole-word candidate. Overflow uses the conditioned operand MSBs.
    always_comb begin
        {cout_d, sum_d} = g_lvl[L].c ? {g_lvl[L].c1[0], g_lvl[L].s1}
                                     : {g_lvl[L].c0[0], g_lvl[L].s0};
        ovf_d = (g_lvl[L].am == g_lvl[L].bm) && (sum_d[WIDTH-1] != g_lvl[L].am);
    end

    // Output register: the result only changes when a valid beat loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (en) begin
            out_valid_q <= g_lvl[L].v;
            if (g_lvl[L].v) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/csa_pipe_adder.md
# csa_pipe_adder

Parametrised, pipelined conditional-sum adder/subtractor with valid/ready flow control. It generalises the fixed 16-bit combinational conditional-sum adder to any power-of-two width and inserts configurable register cuts between merge levels. It also adds a subtract mode, signed-overflow detection and back-pressure, so it can sit directly in streaming datapaths such as ALU pipes and accumulators.

## Interface
- `WIDTH`, default 32: operand width; power of two, 8..64. L = log2(WIDTH) merge levels.
- `REG_EVERY`, default 2: insert a pipeline register after each merge level k where k is a multiple of REG_EVERY and k < L. Range 1..L.
- `clk` input, 1: clock, rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `in_valid` input, 1: operand beat valid.
- `in_ready` output, 1: block accepts a beat this cycle.
- `a` input, WIDTH: operand A.
- `b` input, WIDTH: operand B.
- `cin` input, 1: carry-in; ignored when `sub`=1.
- `sub` input, 1: 0 = add, 1 = subtract (A − B).
- `out_valid` output, 1: result beat valid.
- `out_ready` input, 1: consumer accepts result.
- `sum` output, WIDTH: result.
- `cout` output, 1: carry-out; in subtract mode this is not-borrow.
- `ovf` output, 1: two's-complement signed overflow.

## Operation
- Stage 0 is the input register. It captures a, b' = sub ? ~b : b, and c = sub ? 1 : cin, plus the MSBs a[W-1] and b'[W-1].
- Level 0 is per-bit: sum0 = a^b', carry0 = a&b'; sum1 = ~(a^b'), carry1 = a|b'.
- Level k (1..L) merges pairs of 2^(k-1)-bit blocks. The upper block's carry-0 and carry-1 candidates are selected by the lower block's carry-0 and carry-1 outputs respectively.
- After level L, `c` selects the full {carry,sum} candidate. This value goes to the output register.
- Result: {cout,sum} = a + b' + c, computed exactly in WIDTH+1 bits.
- ovf = (a[W-1] == b'[W-1]) && (sum[W-1] != a[W-1]).
- Pipeline control (global stall): en = !out_valid || out_ready; in_ready = en.
- A beat is accepted when in_valid && in_ready. When en=1 every stage advances and its valid bit follows from the previous stage.
- When en=0 every stage holds, including data and valid bits.
- Bubbles propagate as cleared valid bits. Data registers of invalid stages may hold stale values, but `sum`/`cout`/`ovf` only change when the output stage loads.
- Results emerge strictly in acceptance order. There is no loss or duplication under any out_ready pattern.
- Synthesised logic must use no `+` operator on the full width. The conditional-sum select structure is mandatory.

## Timing
- Latency LAT = 2 + floor((L−1)/REG_EVERY) cycles from the accepting edge to out_valid=1, with out_ready held high.
  - WIDTH=16, REG_EVERY=2: LAT=3.
  - WIDTH=32, REG_EVERY=2: LAT=4.
  - WIDTH=16, REG_EVERY=4: LAT=2.
- Throughput is one beat per cycle while out_ready=1.
- out_valid=1 with out_ready=0 holds sum/cout/ovf/out_valid stable and drives in_ready=0 in the same cycle (combinational from out_valid and out_ready).
- in_valid=1 while in_ready=0: the beat is not accepted, and the source must hold it.
- Reset (rst=1 at an edge) has priority over en. On the next cycle:
  - All stage valid bits = 0.
  - out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
- In-flight beats are discarded, including during a stall. A beat presented with rst=1 is not accepted.
- Simultaneous output pop and input push in a full pipeline is legal: no bubble is inserted.

## Test plan
- **Add wrap.** WIDTH=16, REG_EVERY=2, add a=0xFFFF, b=0x0001, cin=0. Required: sum=0x0000, cout=1, ovf=0, out_valid exactly 3 cycles after accept. Repeat with cin=1: sum=0x0001, cout=1.
- **Subtract.** a=0x0005, b=0x0007, sub=1, cin=1 (ignored). Required: sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1. Required: sum=0x7FFF, cout=1, ovf=1.
- **Signed overflow on add.** a=0x7FFF, b=0x0001, cin=0. Required: sum=0x8000, cout=0, ovf=1.
- **Streaming with back-pressure.** Push 8 back-to-back beats (a=i, b=i·0x1111). Drop out_ready for 4 cycles after the 2nd result. Required:
  - in_ready=0 during the stall.
  - Held output stable during the stall.
  - All 8 results correct, in order, each seen exactly once.
  - Consecutive-cycle output once out_ready returns.
- **Reset mid-operation.** Assert rst for one cycle with 2 beats in flight, one of them stalled at the output. Required: the next cycle has out_valid=0, sum=0, in_ready=1. No stale beat ever appears afterward.
- **Random sweep.** Constrained-random sweep over WIDTH∈{8,16,32,64} × every legal REG_EVERY, with random valid/ready. Required:
  - Scoreboard {cout,sum} = a+b'+c and ovf match.
  - Measured latency equals LAT.
